oq_sram_arbiter: RTL
====================

# oq_sram_arbiter

Shares the single SRAM port of the output-queue subsystem between the packet-store write path (`wr_0_*`) and the packet-remove read path (`rd_0_*`). At most one access is issued per cycle. Arbitration is burst-limited round-robin with a read-to-write bus turnaround bubble. Read data returns in issue order after a fixed pipeline delay. The block sits between the store/remove engines and the SRAM controller pins.

## Interface
- `DATA_WIDTH`, 64, data word width
- `CTRL_WIDTH`, DATA_WIDTH/8, control word width
- `SRAM_ADDR_WIDTH`, 19, SRAM word address width
- `RD_LATENCY`, 3, cycles from `sram_req` (read) to valid `sram_rd_data`; must be ≥1
- `MAX_BURST`, 4, max consecutive grants to one direction while the other direction is waiting; must be ≥1

Ports:
- `clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-low reset
- `wr_0_req`  in  1  write request; held with addr/data until acked
- `wr_0_addr`  in  SRAM_ADDR_WIDTH  write address
- `wr_0_data`  in  DATA_WIDTH+CTRL_WIDTH  write word {ctrl,data}
- `wr_0_ack`  out  1  write granted this cycle
- `rd_0_req`  in  1  read request; held with addr until acked
- `rd_0_addr`  in  SRAM_ADDR_WIDTH  read address
- `rd_0_ack`  out  1  read granted this cycle
- `rd_0_data`  out  DATA_WIDTH+CTRL_WIDTH  returned read word
- `rd_0_vld`  out  1  `rd_0_data` valid
- `sram_req`  out  1  access issued this cycle
- `sram_we`  out  1  1 = write, 0 = read (meaningful only with `sram_req`)
- `sram_addr`  out  SRAM_ADDR_WIDTH  access address
- `sram_wr_data`  out  DATA_WIDTH+CTRL_WIDTH  write word
- `sram_rd_data`  in  DATA_WIDTH+CTRL_WIDTH  read word, valid RD_LATENCY cycles after read issue

## Operation

States:
- IDLE: no direction owned.
- WR: write path owns the port.
- RD: read path owns the port.
- TURN: one-cycle bubble with no grant.

Grant rules:
- Grants are combinational from the `req` inputs and the registered state. `wr_0_ack`/`rd_0_ack` are asserted in the grant cycle.
- A requester sees its ack and may present the next request in the following cycle, so back-to-back grants are possible.
- IDLE: write only → grant write, go to WR. Read only → grant read, go to RD. Both → write wins (protects the input FIFO). Neither → stay IDLE.
- WR or RD: `burst_cnt` counts grants since entering the direction, saturating at MAX_BURST.
  - Own req high and (other req low or `burst_cnt` < MAX_BURST) → grant own.
  - Own req low and other high → switch.
  - `burst_cnt` == MAX_BURST and other high → switch.
  - Neither high → IDLE.
- Switch WR→RD: the read is granted in the same cycle, no bubble.
- Switch RD→WR: go to TURN. No grant, no `sram_req`. The write is granted in the next cycle if `wr_0_req` is still high. Otherwise re-evaluate as IDLE.
- `burst_cnt` loads 1 on the first grant of a new direction.
- A grant is never given to a deasserted req. Both acks are never high together.

Issue and return:
- Issue: on the cycle after a grant, `sram_req`=1 with registered `sram_we`/`sram_addr`/`sram_wr_data`.
- Write data is not held after the issue cycle; `sram_wr_data` keeps its last value.
- Read return: a (RD_LATENCY+1)-deep valid shift register tracks reads in flight. `rd_0_data` registers `sram_rd_data`. Every issued read produces exactly one `rd_0_vld` pulse, in order.

## Timing
- Reset (`reset`=0) forces all outputs to 0, state to IDLE, `burst_cnt` to 0 and clears the valid pipeline. Reads in flight are discarded and never raise `rd_0_vld`.
- Reset deassertion mid-request: the first grant can occur in the first cycle after deassertion.
- Write: ack at T, `sram_req`/`sram_we`=1 at T+1.
- Read: ack at T, `sram_req`=1/`sram_we`=0 at T+1, `sram_rd_data` sampled at T+1+RD_LATENCY, `rd_0_vld`/`rd_0_data` at T+2+RD_LATENCY.
- Throughput:
  - 1 access/cycle except one lost cycle per RD→WR switch.
  - Under continuous contention with MAX_BURST=4: 8 accesses per 9 cycles.
- `rd_0_vld` has no backpressure; the remove path must always accept it.

## Test plan
- Reset: hold `reset`=0 with both reqs high → all outputs 0. Release → write acked in the first cycle, `sram_we`=1 in the next.
- Single write: addr 0x00010, data 0x55_0123456789ABCDEF at T → `wr_0_ack` at T; `sram_req`=1, `sram_we`=1, addr 0x10, same data at T+1; no `rd_0_vld`.
- Single read, RD_LATENCY=3: addr 0x7FFFF at T → ack at T; `sram_req`=1/`sram_we`=0/addr 0x7FFFF at T+1; model drives 0xAA.. at T+4; `rd_0_vld`=1 with 0xAA.. at T+5 only.
- Contention, both reqs held, MAX_BURST=4 → ack pattern W W W W R R R R –(bubble) W W W W R…; no cycle with both acks.
- 8 back-to-back reads to addrs 0..7, SRAM model returns addr as data → 8 consecutive `rd_0_vld` cycles, data 0..7 in order.
- Two reads in flight, then `reset` pulses low for 1 cycle → no `rd_0_vld` afterwards; state IDLE; next write acked normally.

Source files
------------

// File: rtl/oq_sram_arbiter.sv
// Single-port SRAM arbiter for the output queue: burst-limited round-robin between the
// packet-store writes and packet-remove reads, with in-order read return.
module oq_sram_arbiter #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int RD_LATENCY      = 3,
    parameter int MAX_BURST       = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_0_req,
    input  logic [SRAM_ADDR_WIDTH-1:0]       wr_0_addr,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] wr_0_data,
    output logic                             wr_0_ack,
    input  logic                             rd_0_req,
    input  logic [SRAM_ADDR_WIDTH-1:0]       rd_0_addr,
    output logic                             rd_0_ack,
    output logic [DATA_WIDTH+CTRL_WIDTH-1:0] rd_0_data,
    output logic                             rd_0_vld,
    output logic                             sram_req,
    output logic                             sram_we,
    output logic [SRAM_ADDR_WIDTH-1:0]       sram_addr,
    output logic [DATA_WIDTH+CTRL_WIDTH-1:0] sram_wr_data,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] sram_rd_data
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_TURN
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [CNT_W-1:0]   w_burst_next;
    logic [CNT_W-1:0]   w_burst_inc;
    logic               w_burst_full;
    logic               w_wr_grant;
    logic               w_rd_grant;
    logic [RD_LATENCY:0] r_vld_pipe;

    assign w_burst_full = (r_burst_cnt == CNT_W'(MAX_BURST));
    assign w_burst_inc  = w_burst_full ? r_burst_cnt : r_burst_cnt + CNT_W'(1);

    always_comb begin
        w_wr_grant   = 1'b0;
        w_rd_grant   = 1'b0;
        w_state_next = r_state;
        w_burst_next = r_burst_cnt;
        case (r_state)
            S_WR: begin
                if (wr_0_req && (!rd_0_req || !w_burst_full)) begin
                    w_wr_grant   = 1'b1;
                    w_burst_next = w_burst_inc;
                end else if (rd_0_req) begin
                    // write-to-read needs no turnaround, so the read goes out now
                    w_rd_grant   = 1'b1;
                    w_state_next = S_RD;
                    w_burst_next = CNT_W'(1);
                end else begin
                    w_state_next = S_IDLE;
                    w_burst_next = '0;
                end
            end
            S_RD: begin
                if (rd_0_req && (!wr_0_req || !w_burst_full)) begin
                    w_rd_grant   = 1'b1;
                    w_burst_next = w_burst_inc;
                end else if (wr_0_req) begin
                    w_state_next = S_TURN;
                    w_burst_next = '0;
                end else begin
                    w_state_next = S_IDLE;
                    w_burst_next = '0;
                end
            end
            default: begin
                // IDLE and the post-turnaround cycle share the write-first decision
                if (wr_0_req) begin
                    w_wr_grant   = 1'b1;
                    w_state_next = S_WR;
                    w_burst_next = CNT_W'(1);
                end else if (rd_0_req) begin
                    w_rd_grant   = 1'b1;
                    w_state_next = S_RD;
                    w_burst_next = CNT_W'(1);
                end else begin
                    w_state_next = S_IDLE;
                    w_burst_next = '0;
                end
            end
        endcase
        if (!reset) begin
            w_wr_grant = 1'b0;
            w_rd_grant = 1'b0;
        end
    end

    assign wr_0_ack = w_wr_grant;
    assign rd_0_ack = w_rd_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_burst_cnt <= w_burst_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sram_req     <= 1'b0;
            sram_we      <= 1'b0;
            sram_addr    <= '0;
            sram_wr_data <= '0;
        end else begin
            sram_req <= w_wr_grant | w_rd_grant;
            if (w_wr_grant) begin
                sram_we      <= 1'b1;
                sram_addr    <= wr_0_addr;
                sram_wr_data <= wr_0_data;
            end else if (w_rd_grant) begin
                sram_we   <= 1'b0;
                sram_addr <= rd_0_addr;
            end
        end
    end

    // Bit k of the pipe marks a read issued k cycles ago; the top bit lines up with valid SRAM data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_pipe <= '0;
            rd_0_vld   <= 1'b0;
            rd_0_data  <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[RD_LATENCY-1:0], w_rd_grant};
            rd_0_vld   <= r_vld_pipe[RD_LATENCY];
            if (r_vld_pipe[RD_LATENCY]) begin
                rd_0_data <= sram_rd_data;
            end
        end
    end

endmodule
